// File: rtl/dht11_frame_decoder.sv
// DHT11 frame decoder: assembles 40 serial bits, checks the checksum, latches bytes.
// Optional DHT11_STATS_EN adds saturating good/error frame counters.
module dht11_frame_decoder #(
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int FRAME_BITS     = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic       chk_err,
  output logic       timeout,
  output logic       busy
`ifdef DHT11_STATS_EN
  ,
  output logic [7:0] good_cnt,
  output logic [7:0] err_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CLAST = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

  state_t state_q, state_d;

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0] hi_q, hi_d, hd_q, hd_d;
  logic [7:0] ti_q, ti_d, td_q, td_d;
  logic dv_q, dv_d, ce_q, ce_d, to_q, to_d;
  logic [7:0] sum;
  logic last_bit, expire;

  assign sum = sr_q[39:32] + sr_q[31:24]
             + sr_q[23:16] + sr_q[15:8];

  assign last_bit = bit_valid && (cnt_q == CLAST);
  assign expire   = !bit_valid && (tmr_q == TLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (frame_start) state_d = COLLECT;
      COLLECT: begin
        if (frame_start)   state_d = COLLECT;
        else if (last_bit) state_d = CHECK;
        else if (expire)   state_d = IDLE;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    hi_d  = hi_q;
    hd_d  = hd_q;
    ti_d  = ti_q;
    td_d  = td_q;
    dv_d  = 1'b0;
    ce_d  = 1'b0;
    to_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          cnt_d = '0;
          tmr_d = '0;
        end
      end
      COLLECT: begin
        if (frame_start) begin
          cnt_d = '0;
          tmr_d = '0;
        end else if (bit_valid) begin
          sr_d  = {sr_q[FRAME_BITS-2:0], bit_data};
          cnt_d = cnt_q + CW'(1);
          tmr_d = '0;
        end else begin
          if (tmr_q != TMAX) tmr_d = tmr_q + TW'(1);
          to_d = expire;
        end
      end
      CHECK: begin
        if (sum == sr_q[7:0]) begin
          hi_d = sr_q[39:32];
          hd_d = sr_q[31:24];
          ti_d = sr_q[23:16];
          td_d = sr_q[15:8];
          dv_d = 1'b1;
        end else begin
          ce_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      hi_q  <= '0;
      hd_q  <= '0;
      ti_q  <= '0;
      td_q  <= '0;
      dv_q  <= 1'b0;
      ce_q  <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      hi_q  <= hi_d;
      hd_q  <= hd_d;
      ti_q  <= ti_d;
      td_q  <= td_d;
      dv_q  <= dv_d;
      ce_q  <= ce_d;
      to_q  <= to_d;
    end
  end

  assign hum_int    = hi_q;
  assign hum_dec    = hd_q;
  assign temp_int   = ti_q;
  assign temp_dec   = td_q;
  assign data_valid = dv_q;
  assign chk_err    = ce_q;
  assign timeout    = to_q;
  assign busy       = (state_q != IDLE);

`ifdef DHT11_STATS_EN
  logic [7:0] good_q, good_d, err_q, err_d;

  always_comb begin
    good_d = good_q;
    err_d  = err_q;
    if (dv_d && good_q != 8'hFF)
      good_d = good_q + 8'd1;
    if ((ce_d || to_d) && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_q <= '0;
      err_q  <= '0;
    end else begin
      good_q <= good_d;
      err_q  <= err_d;
    end
  end

  assign good_cnt = good_q;
  assign err_cnt  = err_q;
`endif

endmodule

// File: tb/tb_dht11_frame_decoder.sv
// Bench for dht11_frame_decoder: directed and random frames vs a byte-level model.
// Build with DHT11_STATS_EN to also check the frame counters.
module tb_dht11_frame_decoder;

  localparam int T = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_data = 1'b0;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic data_valid, chk_err, timeout, busy;
`ifdef DHT11_STATS_EN
  logic [7:0] good_cnt, err_cnt;
  int m_good = 0;
  int m_err = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // model state: bytes of the last good frame
  logic [7:0] m_hi = 0, m_hd = 0, m_ti = 0, m_td = 0;

  dht11_frame_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .bit_valid(bit_valid),
    .bit_data(bit_data),
    .hum_int(hum_int),
    .hum_dec(hum_dec),
    .temp_int(temp_int),
    .temp_dec(temp_dec),
    .data_valid(data_valid),
    .chk_err(chk_err),
    .timeout(timeout),
    .busy(busy)
`ifdef DHT11_STATS_EN
    ,
    .good_cnt(good_cnt),
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, ".hum_int"}, 64'(hum_int), 64'(m_hi));
    chk({tag, ".hum_dec"}, 64'(hum_dec), 64'(m_hd));
    chk({tag, ".temp_int"}, 64'(temp_int), 64'(m_ti));
    chk({tag, ".temp_dec"}, 64'(temp_dec), 64'(m_td));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".pulses"},
        64'({data_valid, chk_err, timeout}), 64'(0));
  endtask

  task automatic put_bit(input logic b);
    bit_valid = 1'b1;
    bit_data  = b;
    cyc();
    bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // frame_start then 40 bits; gaps random up to maxgap,
  // except bit index slow_at gets a T-1 cycle gap.
  task automatic send_frame(input string tag,
                            input logic [39:0] f,
                            input int maxgap,
                            input int slow_at,
                            input bit fs_with_bit);
    int s;
    bit ok;
    frame_start = 1'b1;
    if (fs_with_bit) begin
      bit_valid = 1'b1;
      bit_data  = 1'b1;
    end
    cyc();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    chk({tag, ".busy_start"}, 64'(busy), 64'(1));
    for (int i = 0; i < 40; i++) begin
      if (i == slow_at) idle(T - 1);
      else idle($urandom_range(maxgap, 0));
      put_bit(f[39-i]);
    end
    chk({tag, ".busy_check"}, 64'(busy), 64'(1));
    chk_quiet({tag, ".k"});
    s = (int'(f[39:32]) + int'(f[31:24]) +
         int'(f[23:16]) + int'(f[15:8])) % 256;
    ok = (s == int'(f[7:0]));
    if (ok) begin
      m_hi = f[39:32];
      m_hd = f[31:24];
      m_ti = f[23:16];
      m_td = f[15:8];
`ifdef DHT11_STATS_EN
      if (m_good < 255) m_good++;
    end else begin
      if (m_err < 255) m_err++;
`endif
    end
    cyc();
    chk({tag, ".data_valid"}, 64'(data_valid), 64'(ok));
    chk({tag, ".chk_err"}, 64'(chk_err), 64'(!ok));
    chk({tag, ".timeout"}, 64'(timeout), 64'(0));
    chk_bytes(tag);
    cyc();
    chk_quiet({tag, ".k2"});
    chk({tag, ".busy_end"}, 64'(busy), 64'(0));
  endtask

  function automatic logic [39:0] mk(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input logic [7:0] c,
                                     input logic [7:0] d,
                                     input bit good);
    logic [7:0] s;
    s = 8'((int'(a) + int'(b) + int'(c) + int'(d)) % 256);
    if (!good) s = s ^ 8'(1 << $urandom_range(7, 0));
    return {a, b, c, d, s};
  endfunction

  initial begin
    int n;
    logic [39:0] f;

    idle(3);
    chk("reset.pulses",
        64'({data_valid, chk_err, timeout, busy}), 64'(0));
    chk_bytes("reset");
    rst = 1'b1;
    idle(2);

    send_frame("f37", 40'h3700190050, 2, -1, 0);
    send_frame("f37bad", 40'h3700190051, 2, -1, 0);
    send_frame("wrap", 40'hFF01000000, 1, -1, 0);

    // timeout after 20 bits
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 0; i < 20; i++) put_bit(1'($urandom));
    n = 0;
    while (n < T + 5) begin
      cyc();
      n++;
      if (timeout) break;
    end
    chk("to.latency", 64'(n), 64'(T));
    chk("to.busy", 64'(busy), 64'(0));
    chk("to.others", 64'({data_valid, chk_err}), 64'(0));
    chk_bytes("to");
`ifdef DHT11_STATS_EN
    if (m_err < 255) m_err++;
`endif
    cyc();
    chk_quiet("to.after");
    send_frame("post_to", 40'h2A05170339, 2, -1, 0);

    // restart mid-frame
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      put_bit(1'($urandom));
      chk_quiet("restart.mid");
    end
    send_frame("restart", 40'h28001E0046, 2, -1, 0);

    // frame_start with a coincident bit; the bit is dropped
    send_frame("fs_bit", mk(8'h41, 8'h02, 8'h16, 8'h07, 1),
               1, -1, 1);

    // a bit arriving exactly as the timer expires wins
    send_frame("slow", mk(8'h33, 8'h09, 8'h12, 8'h04, 1),
               1, 25, 0);

    for (int r = 0; r < 8; r++) begin
      f = mk(8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), r % 3 != 1);
      send_frame("rand", f, 3, -1, 0);
    end

`ifdef DHT11_STATS_EN
    chk("stats.good", 64'(good_cnt), 64'(m_good));
    chk("stats.err", 64'(err_cnt), 64'(m_err));
`endif

    // asynchronous reset after 30 bits
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 0; i < 30; i++) put_bit(1'($urandom));
    rst = 1'b0;
    #2;
    m_hi = 0;
    m_hd = 0;
    m_ti = 0;
    m_td = 0;
    chk("rst.async_bytes",
        64'({hum_int, hum_dec, temp_int, temp_dec}), 64'(0));
    chk("rst.async_flags",
        64'({data_valid, chk_err, timeout, busy}), 64'(0));
`ifdef DHT11_STATS_EN
    m_good = 0;
    m_err = 0;
    chk("rst.stats", 64'({good_cnt, err_cnt}), 64'(0));
`endif
    cyc();
    rst = 1'b1;
    cyc();

    // bit strobes in IDLE do nothing
    for (int i = 0; i < 50; i++) begin
      bit_valid = 1'($urandom);
      bit_data  = 1'($urandom);
      cyc();
      if (i % 10 == 9) begin
        chk_quiet("idle.bits");
        chk("idle.busy", 64'(busy), 64'(0));
      end
    end
    bit_valid = 1'b0;
    chk_bytes("idle");
    send_frame("final", 40'h3C0417026D, 2, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
